uart_rx_fifo_interface: RTL and testbench

//  Receive-side buffer between the UART receiver and the Crypter.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_fifo_interface_pkg.sv | 14 +
 rtl/uart_rx_fifo_interface_if.sv | 31 +++
 rtl/uart_rx_fifo_interface_mem.sv | 23 ++
 rtl/uart_rx_fifo_interface.sv | 89 ++++++++
 tb/tb_uart_rx_fifo_interface.sv | 142 ++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive path and the Crypter.
package uart_pkg;
  localparam logic [7:0] ASCII_EOT   = 8'h04;
  localparam int         UART_DATA_W = 8;
endpackage

// File: rtl/uart_rx_fifo_interface_pkg.sv
// Defaults and operation encoding for the UART receive-side FIFO.
package uart_rx_fifo_interface_pkg;
  localparam int         RX_FIFO_DATA_W = uart_pkg::UART_DATA_W;
  localparam int         RX_FIFO_DEPTH  = 4;
  localparam logic [7:0] RX_FIFO_EOT    = uart_pkg::ASCII_EOT;

  // Encoded as {push, pop}
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;
endpackage

// File: rtl/uart_rx_fifo_interface_if.sv
// Handshake bundle between UART_RX/Crypter (master) and the receive FIFO (slave).
// RX_FIFO_OVF_EN adds the sticky overflow flag and its clear strobe.
interface uart_rx_fifo_interface_if
  import uart_rx_fifo_interface_pkg::*;
#(
  parameter int DATA_W = RX_FIFO_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH
);
  logic                       set_flag;
  logic [DATA_W-1:0]          data_in;
  logic                       clear_flag;
  logic                       flag;
  logic [DATA_W-1:0]          data_out;
  logic                       eot;
  logic                       full;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef RX_FIFO_OVF_EN
  logic                       overflow;
  logic                       overflow_clr;

  modport master (output set_flag, data_in, clear_flag, overflow_clr,
                  input  flag, data_out, eot, full, count, overflow);
  modport slave  (input  set_flag, data_in, clear_flag, overflow_clr,
                  output flag, data_out, eot, full, count, overflow);
`else
  modport master (output set_flag, data_in, clear_flag,
                  input  flag, data_out, eot, full, count);
  modport slave  (input  set_flag, data_in, clear_flag,
                  output flag, data_out, eot, full, count);
`endif
endinterface

// File: rtl/uart_rx_fifo_interface_mem.sv
// DEPTH x DATA_W storage for the receive FIFO: synchronous write, asynchronous read, no reset.
module rx_fifo_mem
  import uart_rx_fifo_interface_pkg::*;
#(
  parameter int DATA_W = RX_FIFO_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo_interface.sv
// Receive-side FIFO between UART_RX and the Crypter; flags EOT when the head word is EOT_CHAR.
// Optional macro RX_FIFO_OVF_EN adds a sticky overflow indicator for dropped pushes.
module uart_rx_fifo_interface
  import uart_rx_fifo_interface_pkg::*;
#(
  parameter int                DATA_W   = RX_FIFO_DATA_W,
  parameter int                DEPTH    = RX_FIFO_DEPTH,
  parameter logic [DATA_W-1:0] EOT_CHAR = DATA_W'(RX_FIFO_EOT)
) (
  input logic                clk,
  input logic                rst_n,
  uart_rx_fifo_interface_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] head;
  logic              flag;
  logic              full;
  logic              push;
  logic              pop;
  fifo_op_e          op;

  assign flag = (count_q != '0);
  assign full = (count_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push = bus.set_flag && (!full || bus.clear_flag);
  assign pop  = bus.clear_flag && flag;
  assign op   = fifo_op_e'({push, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end
        FIFO_POP: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count_q <= count_q - 1'b1;
        end
        FIFO_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.flag     = flag;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.data_out = flag ? head : '0;
  assign bus.eot      = flag && (head == EOT_CHAR);

`ifdef RX_FIFO_OVF_EN
  logic overflow_q;

  // A drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          overflow_q <= 1'b0;
    else if (bus.set_flag && full && !bus.clear_flag)    overflow_q <= 1'b1;
    else if (bus.overflow_clr)                           overflow_q <= 1'b0;
  end

  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_interface.sv
// Scoreboard bench for uart_rx_fifo_interface: reference queue tracks accepted words.
module tb_uart_rx_fifo_interface;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_interface_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo_interface #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .EOT_CHAR (8'h04)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic exp_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [DATA_W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_val("count",    32'(bus.count), exp_q.size());
    check_val("flag",     32'(bus.flag),  32'(exp_q.size() > 0));
    check_val("full",     32'(bus.full),  32'(exp_q.size() == DEPTH));
    check_val("data_out", 32'(bus.data_out), 32'(head));
    check_val("eot",      32'(bus.eot),   32'((exp_q.size() > 0) && (head == 8'h04)));
`ifdef RX_FIFO_OVF_EN
    check_val("overflow", 32'(bus.overflow), 32'(exp_ovf));
`endif
  endtask

  task automatic do_cycle(input bit push, input logic [DATA_W-1:0] din, input bit pop,
                          input bit oclr = 1'b0);
    bit m_push;
    bit m_pop;
    logic [DATA_W-1:0] dummy;
    m_pop  = pop && (exp_q.size() > 0);
    m_push = push && ((exp_q.size() < DEPTH) || pop);
    if (m_pop) begin
      check_val("pop_data", 32'(bus.data_out), 32'(exp_q[0]));
      dummy = exp_q.pop_front();
    end
    if (m_push) exp_q.push_back(din);
    if (push && !m_push)  exp_ovf = 1'b1;
    else if (oclr)        exp_ovf = 1'b0;
    bus.set_flag   = push;
    bus.data_in    = din;
    bus.clear_flag = pop;
`ifdef RX_FIFO_OVF_EN
    bus.overflow_clr = oclr;
`endif
    @(posedge clk);
    #1;
    bus.set_flag   = 1'b0;
    bus.clear_flag = 1'b0;
`ifdef RX_FIFO_OVF_EN
    bus.overflow_clr = 1'b0;
`endif
    check_state();
  endtask

  initial begin
    bus.set_flag   = 1'b0;
    bus.data_in    = '0;
    bus.clear_flag = 1'b0;
`ifdef RX_FIFO_OVF_EN
    bus.overflow_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_state();

    // Push 41, 42, 04; drain watching eot only on 04
    do_cycle(1, 8'h41, 0);
    do_cycle(1, 8'h42, 0);
    do_cycle(1, 8'h04, 0);
    do_cycle(0, 8'h00, 1);
    do_cycle(0, 8'h00, 1);
    do_cycle(0, 8'h00, 1);
    do_cycle(0, 8'h00, 1);

    // Fill, then drop 55 while full
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 8'(8'h10 + i), 0);
    do_cycle(1, 8'h55, 0);
    do_cycle(0, 8'h00, 0);
`ifdef RX_FIFO_OVF_EN
    do_cycle(0, 8'h00, 0, 1'b1);
    do_cycle(1, 8'h56, 0, 1'b1);
    do_cycle(0, 8'h00, 0, 1'b1);
`endif

    // Full push+pop keeps count, new word goes to tail
    do_cycle(1, 8'h66, 1);
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 8'h00, 1);

    // Empty push+pop: push accepted, pop ignored
    do_cycle(1, 8'h77, 1);
    do_cycle(1, 8'h78, 1);
    do_cycle(0, 8'h00, 1);

    // Alternating push/pop 0..9 wraps the pointers
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 8'(i), 0);
      check_val("count_le1", 32'(bus.count <= 1), 32'd1);
      do_cycle(0, 8'h00, 1);
    end

    // Async reset with three words held
    do_cycle(1, 8'hA1, 0);
    do_cycle(1, 8'hA2, 0);
    do_cycle(1, 8'h04, 0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_state();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_state();
    do_cycle(1, 8'h5A, 0);
    do_cycle(0, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
